serial_magnitude_compare: RTL and testbench

Multi-cycle magnitude comparator controller for two unsigned W-bit operands. A start/ready/done handshake sequences a 2-bit greater-than/equal slice over the operand pairs, most significant pair first. It produces a registered gt/eq/lt verdict. The block sits between control logic that needs wide comparisons and the 2-bit comparison datapath, so one small slice is reused instead of a full-width comparator.

---
 rtl/serial_magnitude_compare.sv | 121 ++++++++++++
 tb/tb_serial_magnitude_compare.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_compare.sv
// Multi-cycle unsigned magnitude comparator that reuses one 2-bit slice per cycle, starting at the MSB pair.
// Define SERIAL_CMP_EARLY_EXIT_EN to stop at the first differing pair; otherwise every pair is always evaluated.
module serial_magnitude_compare #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         ready_o,
  output logic         done_tick_o,
  output logic         gt_o,
  output logic         eq_o,
  output logic         lt_o
);
  localparam int NP = W / 2;
  localparam int CW = $clog2(NP) + 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   sa_q, sb_q;
  logic [CW-1:0]  cnt_q;
  logic           gt_q, eq_q, lt_q;
  logic [1:0]     pa, pb;
  logic           pair_gt, pair_lt, last_pair;

  function automatic logic gt2(input logic [1:0] x, input logic [1:0] y);
    return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
  endfunction

  assign pa        = sa_q[W-1 -: 2];
  assign pb        = sb_q[W-1 -: 2];
  assign pair_gt   = gt2(pa, pb);
  assign pair_lt   = gt2(pb, pa);
  assign last_pair = (cnt_q == CW'(1));

`ifndef SERIAL_CMP_EARLY_EXIT_EN
  // Sticky decision: the first differing pair wins, later pairs cannot override it.
  logic dgt_q, dlt_q, dgt_d, dlt_d;
  always_comb begin
    dgt_d = dgt_q | (pair_gt & ~dlt_q);
    dlt_d = dlt_q | (pair_lt & ~dgt_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
      dgt_q   <= 1'b0;
      dlt_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sa_q    <= a_i;
            sb_q    <= b_i;
            cnt_q   <= CW'(NP);
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            dgt_q   <= 1'b0;
            dlt_q   <= 1'b0;
`endif
            state_q <= CMP;
          end
        end
        CMP: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          if (pair_gt) begin
            gt_q    <= 1'b1;
            state_q <= DONE;
          end else if (pair_lt) begin
            lt_q    <= 1'b1;
            state_q <= DONE;
          end else if (last_pair) begin
            eq_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            sa_q  <= sa_q << 2;
            sb_q  <= sb_q << 2;
            cnt_q <= cnt_q - CW'(1);
          end
`else
          if (last_pair) begin
            gt_q    <= dgt_d;
            lt_q    <= dlt_d;
            eq_q    <= ~(dgt_d | dlt_d);
            state_q <= DONE;
          end else begin
            dgt_q <= dgt_d;
            dlt_q <= dlt_d;
            sa_q  <= sa_q << 2;
            sb_q  <= sb_q << 2;
            cnt_q <= cnt_q - CW'(1);
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign done_tick_o = (state_q == DONE);
  assign gt_o        = gt_q;
  assign eq_o        = eq_q;
  assign lt_o        = lt_q;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Directed bench for serial_magnitude_compare: an 8-bit instance for the main cases and a 2-bit
// instance driven with start held high; expected verdicts and latencies are queued at start and popped at done.
module tb_serial_magnitude_compare;
  logic       clk = 1'b0;
  logic       reset, start, start2;
  logic [7:0] a, b;
  logic [1:0] a2, b2;
  logic       ready, done, gt, eq, lt;
  logic       ready2, done2, gt2, eq2, lt2;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;

  typedef struct {
    logic g;
    logic e;
    logic l;
    int   lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  serial_magnitude_compare #(.W(8)) dut (
    .clk(clk), .reset_i(reset), .start_i(start), .a_i(a), .b_i(b),
    .ready_o(ready), .done_tick_o(done), .gt_o(gt), .eq_o(eq), .lt_o(lt)
  );

  serial_magnitude_compare #(.W(2)) dut2 (
    .clk(clk), .reset_i(reset), .start_i(start2), .a_i(a2), .b_i(b2),
    .ready_o(ready2), .done_tick_o(done2), .gt_o(gt2), .eq_o(eq2), .lt_o(lt2)
  );

  always @(posedge clk) if (done) n_done <= n_done + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Index (1 = MSB pair) of the first differing 2-bit pair, or 4 when equal.
  function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
    for (int k = 1; k <= 4; k++)
      if (x[(9 - 2 * k) -: 2] != y[(9 - 2 * k) -: 2]) return k;
    return 4;
  endfunction

  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv, input bit poke);
    exp_t e, got;
    int   lat;
    int   d0;
    bit   seen;
    e.g = (av > bv);
    e.e = (av == bv);
    e.l = (av < bv);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    e.lat = first_diff(av, bv) + 1;
`else
    e.lat = 4 + 1;
`endif
    sb_q.push_back(e);
    d0 = n_done;
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_cleared"}, {29'd0, gt, eq, lt}, 0);
    if (poke) begin
      a = 8'hFF; b = 8'h00; start = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    got = sb_q.pop_front();
    check({tag, "_gt"}, int'(gt), int'(got.g));
    check({tag, "_eq"}, int'(eq), int'(got.e));
    check({tag, "_lt"}, int'(lt), int'(got.l));
    check({tag, "_latency"}, lat, got.lat);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ready_back"}, int'(ready), 1);
    check({tag, "_one_done"}, n_done - d0, 1);
    $display("vector %s a=%02h b=%02h gt=%0b eq=%0b lt=%0b latency=%0d", tag, av, bv, gt, eq, lt, lat);
  endtask

  initial begin
    int  d0;
    int  gap;
    bit  seen;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    a = '0; b = '0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_verdict", {29'd0, gt, eq, lt}, 0);
    check("rst_ready_w2", int'(ready2), 1);
    reset = 1'b0;
    @(negedge clk);

    run_cmp("gt_msb", 8'hC3, 8'h43, 1'b0);
    run_cmp("equal", 8'hA5, 8'hA5, 1'b0);
    run_cmp("lt_lsb", 8'h12, 8'h13, 1'b0);
    run_cmp("zero_vs_ones", 8'h00, 8'hFF, 1'b0);
    run_cmp("ones_vs_zero", 8'hFF, 8'h00, 1'b0);
    run_cmp("busy_ignore", 8'h12, 8'h13, 1'b1);

    // Abort mid-compare: reset sampled on the edge ending the 2nd CMP cycle.
    d0 = n_done;
    a = 8'h12; b = 8'h13; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", int'(ready), 1);
    check("abort_verdict", {29'd0, gt, eq, lt}, 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    $display("vector abort_mid_cmp ready=%0b gt=%0b eq=%0b lt=%0b", ready, gt, eq, lt);
    run_cmp("after_abort", 8'h81, 8'h80, 1'b0);

    // W=2 instance with start held high: one comparison every 3 cycles.
    a2 = 2'b10; b2 = 2'b01; start2 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      seen = 1'b0;
      gap = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        gap++;
        @(negedge clk);
        if (done2) begin
          seen = 1'b1;
          break;
        end
      end
      check("w2_done_seen", int'(seen), 1);
      check("w2_verdict", {29'd0, gt2, eq2, lt2}, 3'b100);
      if (p > 0) check("w2_period", gap, 3);
      $display("vector w2_continuous pass=%0d gt=%0b eq=%0b lt=%0b gap=%0d", p, gt2, eq2, lt2, gap);
    end
    start2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
